// File: rtl/trace_pkg.sv
// Shared trace-path constants.
// Word width and frame length used by the frame buffer, plus the
// header bit positions the SPI stage places in the first word of a frame.
package trace_pkg;

  localparam int unsigned TRACE_WORD_W = 16;
  localparam int unsigned FRAME_WORDS  = 8;

  // Header word layout (first word of each SPI trace frame)
  localparam int unsigned HDR_SEQ_LSB  = 0;
  localparam int unsigned HDR_SEQ_MSB  = 7;
  localparam int unsigned HDR_OVF_BIT  = 14;
  localparam int unsigned HDR_SYNC_BIT = 15;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector.
// Ports:
//   clk       master clock
//   rst       synchronous active-low reset
//   async_i   asynchronous level input
//   rise_c_o  one-cycle pulse, high the cycle after the synchronised level rises
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_c_o
);

  logic [2:0] sh_q;
  logic [2:0] sh_d;

  // sh_q[1:0] synchronise, sh_q[2] holds the previous synchronised level
  assign sh_d = {sh_q[1:0], async_i};

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign rise_c_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/trace_frame_buffer.sv
// Frame-aligned FIFO between the trace word packer and the SPI host link.
// Words are written speculatively and become visible to the reader only
// when a whole frame has been accepted; the reader pops one word per
// synchronised tx_free rising edge.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   wr_word/valid  trace word from packer and its valid strobe
//   sync           packer synchronised; words ignored while low, fall aborts frame
//   rxFrameReset   discard the partially written frame
//   tx_free        asynchronous pop request from the SPI stage
//   tx_word        registered head word (0 when nothing committed)
//   transmitIn     registered: at least one complete frame held
//   frames_avail   committed frames not yet fully read
//   overflow       sticky frame-drop flag, cleared by overflow_clr
module trace_frame_buffer #(
  parameter int unsigned DEPTH_LOG2  = 5,
  parameter int unsigned FRAME_WORDS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           wr_word,
  input  logic                  wr_valid,
  input  logic                  sync,
  input  logic                  rxFrameReset,
  input  logic                  tx_free,
  output logic [15:0]           tx_word,
  output logic                  transmitIn,
  output logic [DEPTH_LOG2-3:0] frames_avail,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  import trace_pkg::*;

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
  localparam int unsigned FC_W  = $clog2(FRAME_WORDS);
  localparam int unsigned FA_W  = DEPTH_LOG2 - 2;

  logic [TRACE_WORD_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [FA_W-1:0]  fa_q, fa_d;
  logic             dropping_q, dropping_d;
  logic             ovf_q, ovf_d;
  logic             xmit_q, xmit_d;
  logic             sync_q;
  logic [15:0]      tx_word_q, tx_word_d;

  logic             pop_req_c;
  logic             word_in_c, full_c, frame_end_c, accept_c, overrun_c;
  logic             commit_c, abort_c, pop_c, pop_frame_c;
  logic [PTR_W-1:0] rd_next_c;

  sync_edge u_tx_free_sync (
    .clk      (clk),
    .rst      (rst),
    .async_i  (tx_free),
    .rise_c_o (pop_req_c)
  );

  // Write/read qualification
  always_comb begin
    word_in_c   = wr_valid & sync & ~rxFrameReset;
    full_c      = (wr_ptr_q - rd_ptr_q) == PTR_W'(DEPTH);
    frame_end_c = fcnt_q == FC_W'(FRAME_WORDS - 1);
    accept_c    = word_in_c & ~dropping_q & ~full_c;
    overrun_c   = word_in_c & ~dropping_q & full_c;
    commit_c    = accept_c & frame_end_c;
    abort_c     = rxFrameReset | (sync_q & ~sync);
    pop_c       = pop_req_c & (rd_ptr_q != cm_ptr_q);
    rd_next_c   = rd_ptr_q + PTR_W'(1);
    pop_frame_c = pop_c & (rd_next_c[FC_W-1:0] == '0);
  end

  // Next-state logic
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    cm_ptr_d   = cm_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fcnt_d     = fcnt_q;
    fa_d       = fa_q;
    dropping_d = dropping_q;
    ovf_d      = ovf_q;

    if (abort_c) begin
      wr_ptr_d   = cm_ptr_q;
      fcnt_d     = '0;
      dropping_d = 1'b0;
    end else if (word_in_c) begin
      // Frame position advances for dropped words too, keeping frame alignment
      fcnt_d = fcnt_q + FC_W'(1);
      if (accept_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (commit_c) cm_ptr_d = wr_ptr_q + PTR_W'(1);
      if (overrun_c) begin
        wr_ptr_d   = cm_ptr_q;
        dropping_d = 1'b1;
      end
      if (frame_end_c) dropping_d = 1'b0;
    end

    if (overrun_c) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end

    if (pop_c) rd_ptr_d = rd_next_c;

    case ({commit_c, pop_frame_c})
      2'b10:   fa_d = fa_q + FA_W'(1);
      2'b01:   fa_d = fa_q - FA_W'(1);
      default: fa_d = fa_q;
    endcase

    xmit_d    = fa_q != '0;
    tx_word_d = (rd_ptr_q != cm_ptr_q) ? mem_q[rd_ptr_q[DEPTH_LOG2-1:0]] : '0;
  end

  // Storage write port (no reset: inferred RAM)
  always_ff @(posedge clk) begin
    if (accept_c) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      cm_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
      fa_q       <= '0;
      dropping_q <= 1'b0;
      ovf_q      <= 1'b0;
      xmit_q     <= 1'b0;
      sync_q     <= 1'b0;
      tx_word_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      cm_ptr_q   <= cm_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
      fa_q       <= fa_d;
      dropping_q <= dropping_d;
      ovf_q      <= ovf_d;
      xmit_q     <= xmit_d;
      sync_q     <= sync;
      tx_word_q  <= tx_word_d;
    end
  end

  assign tx_word      = tx_word_q;
  assign transmitIn   = xmit_q;
  assign frames_avail = fa_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_trace_frame_buffer.sv
// Directed bench for trace_frame_buffer (DEPTH_LOG2=5, FRAME_WORDS=8).
module tb_trace_frame_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wr_word;
  logic        wr_valid;
  logic        sync;
  logic        rxFrameReset;
  logic        tx_free;
  logic [15:0] tx_word;
  logic        transmitIn;
  logic [2:0]  frames_avail;
  logic        overflow;
  logic        overflow_clr;

  int n_checks = 0;
  int n_pass   = 0;

  trace_frame_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .wr_word      (wr_word),
    .wr_valid     (wr_valid),
    .sync         (sync),
    .rxFrameReset (rxFrameReset),
    .tx_free      (tx_free),
    .tx_word      (tx_word),
    .transmitIn   (transmitIn),
    .frames_avail (frames_avail),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_word(input logic [15:0] w);
    wr_word  = w;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  // tx_free high 4 clocks then low 4: pop lands 3 edges after the rise
  task automatic pop_pulse();
    tx_free = 1'b1;
    repeat (4) tick();
    tx_free = 1'b0;
    repeat (4) tick();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) pop_pulse();
  endtask

  initial begin
    rst = 1'b0; wr_word = '0; wr_valid = 1'b0; sync = 1'b0;
    rxFrameReset = 1'b0; tx_free = 1'b0; overflow_clr = 1'b0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b1;
    check_eq("rst_tx_word", 32'(tx_word), 32'h0);
    check_eq("rst_transmitIn", 32'(transmitIn), 32'h0);
    check_eq("rst_frames_avail", 32'(frames_avail), 32'h0);
    check_eq("rst_overflow", 32'(overflow), 32'h0);
    sync = 1'b1;
    tick();

    // One frame 0x0001..0x0008
    for (int i = 1; i <= 8; i++) write_word(16'(i));
    check_eq("commit_frames_avail", 32'(frames_avail), 32'h1);
    tick();
    check_eq("frame1_transmitIn", 32'(transmitIn), 32'h1);
    check_eq("frame1_tx_word", 32'(tx_word), 32'h0001);
    check_eq("frame1_frames_avail", 32'(frames_avail), 32'h1);

    // Pop it out word by word
    for (int k = 2; k <= 9; k++) begin
      pop_pulse();
      check_eq("pop_tx_word", 32'(tx_word), (k <= 8) ? 32'(k) : 32'h0);
      check_eq("pop_transmitIn", 32'(transmitIn), 32'(k <= 8));
    end
    check_eq("drained_frames_avail", 32'(frames_avail), 32'h0);

    // Partial frame discarded by rxFrameReset
    for (int i = 0; i < 5; i++) write_word(16'(16'h0AA0 + i));
    rxFrameReset = 1'b1;
    tick();
    rxFrameReset = 1'b0;
    for (int i = 0; i < 8; i++) write_word(16'(16'h0100 + i));
    tick();
    check_eq("rfr_frames_avail", 32'(frames_avail), 32'h1);
    check_eq("rfr_head", 32'(tx_word), 32'h0100);
    for (int i = 1; i <= 8; i++) begin
      pop_pulse();
      check_eq("rfr_tx_word", 32'(tx_word), (i < 8) ? 32'(16'h0100 + i) : 32'h0);
    end
    check_eq("rfr_empty", 32'(frames_avail), 32'h0);

    // Falling sync discards the partial frame; words ignored while low
    for (int i = 0; i < 3; i++) write_word(16'(16'h0700 + i));
    sync = 1'b0;
    write_word(16'h07FF);
    tick();
    sync = 1'b1;
    for (int i = 0; i < 8; i++) write_word(16'(16'h0800 + i));
    tick();
    check_eq("sync_head", 32'(tx_word), 32'h0800);
    check_eq("sync_frames_avail", 32'(frames_avail), 32'h1);
    drain(8);
    check_eq("sync_empty", 32'(frames_avail), 32'h0);

    // Reset with 1.5 frames held
    for (int i = 0; i < 12; i++) write_word(16'(16'h0200 + i));
    check_eq("pre_rst_frames_avail", 32'(frames_avail), 32'h1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_eq("mid_rst_tx_word", 32'(tx_word), 32'h0);
    check_eq("mid_rst_transmitIn", 32'(transmitIn), 32'h0);
    check_eq("mid_rst_frames_avail", 32'(frames_avail), 32'h0);
    check_eq("mid_rst_overflow", 32'(overflow), 32'h0);
    pop_pulse();
    check_eq("ign_pop_tx_word", 32'(tx_word), 32'h0);
    check_eq("ign_pop_frames_avail", 32'(frames_avail), 32'h0);
    for (int i = 0; i < 8; i++) write_word(16'(16'h0300 + i));
    tick();
    check_eq("post_rst_head", 32'(tx_word), 32'h0300);
    check_eq("post_rst_frames_avail", 32'(frames_avail), 32'h1);
    drain(8);

    // Five frames into a four-frame buffer
    for (int f = 1; f <= 5; f++)
      for (int i = 0; i < 8; i++) write_word(16'((f << 8) | i));
    tick();
    check_eq("ovf_frames_avail", 32'(frames_avail), 32'h4);
    check_eq("ovf_flag", 32'(overflow), 32'h1);
    check_eq("ovf_transmitIn", 32'(transmitIn), 32'h1);
    check_eq("ovf_head", 32'(tx_word), 32'h0100);
    for (int n = 1; n <= 32; n++) begin
      pop_pulse();
      check_eq("ovf_tx_word", 32'(tx_word),
               (n < 32) ? 32'((((n / 8) + 1) << 8) | (n % 8)) : 32'h0);
    end
    check_eq("ovf_drained", 32'(frames_avail), 32'h0);
    check_eq("ovf_sticky", 32'(overflow), 32'h1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check_eq("ovf_cleared", 32'(overflow), 32'h0);
    for (int i = 0; i < 8; i++) write_word(16'(16'h0600 + i));
    tick();
    check_eq("post_ovf_head", 32'(tx_word), 32'h0600);
    check_eq("post_ovf_frames_avail", 32'(frames_avail), 32'h1);
    drain(8);

    // Last pop of frame A on the same edge as the commit of frame C
    for (int i = 0; i < 8; i++) write_word(16'(16'h0A00 + i));
    for (int i = 0; i < 8; i++) write_word(16'(16'h0B00 + i));
    for (int i = 0; i < 7; i++) write_word(16'(16'h0C00 + i));
    check_eq("ab_frames_avail", 32'(frames_avail), 32'h2);
    drain(7);
    check_eq("a7_tx_word", 32'(tx_word), 32'h0A07);
    tx_free = 1'b1;
    tick();
    tick();
    wr_word  = 16'h0C07;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    check_eq("net0_frames_avail", 32'(frames_avail), 32'h2);
    tick();
    check_eq("net0_transmitIn", 32'(transmitIn), 32'h1);
    check_eq("net0_tx_word", 32'(tx_word), 32'h0B00);
    tx_free = 1'b0;
    repeat (4) tick();
    check_eq("net0_hold_frames_avail", 32'(frames_avail), 32'h2);
    drain(8);
    check_eq("c_head", 32'(tx_word), 32'h0C00);
    check_eq("c_frames_avail", 32'(frames_avail), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
